instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Inverse of immediate generation: packs opcode, register fields and a 32-bit signed immediate into a RV32I word.
//  Uses the same 3-bit format selector as the decode side. Range/alignment checks fail to NOP + error.
//  Expands LI pseudo-op (rd <- imm32) into LUI+ADDI, or a single ADDI when imm fits 12 bits.
//  Feeds boot-ROM loader / debug program-buffer writes into instruction memory.
//  Tags each output word with a running byte address.
// PARAMETERS
//  WIDTH      32  instruction/immediate/address width (only 32 supported)
//  ADDR_STEP  4   byte increment of out_addr per emitted word
// PORTS
//  clk        in   1      clock
//  rst        in   1      asynchronous active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid && in_ready
//  in_fmt     in   3      format: I=000 S=001 SB=010 U=011 UJ=100 SH=101 LI=110 R=111
//  in_opcode  in   7      opcode[6:0] (ignored for LI)
//  in_rd      in   5      rd
//  in_rs1     in   5      rs1
//  in_rs2     in   5      rs2
//  in_funct3  in   3      funct3
//  in_funct7  in   7      funct7 (R, SH)
//  in_imm     in   WIDTH  full signed immediate / byte offset (U: full value, low 12 bits must be 0)
//  addr_load  in   1      load address counter
//  addr_base  in   WIDTH  new counter value
//  out_valid  out  1      output word valid
//  out_ready  in   1      downstream accept
//  out_instr  out  WIDTH  encoded instruction
//  out_addr   out  WIDTH  byte address of out_instr
//  out_err    out  1      request failed range/alignment check; out_instr is NOP 0x00000013
// BEHAVIOUR
//  Reset (async, immediate): out_valid=0, out_instr=0, out_addr=0, out_err=0, pc_q=0, state=S_IDLE.
//  Output register holds the word; out_* stay stable while out_valid && !out_ready.
//  in_ready = (state==S_IDLE) && (!out_valid || out_ready). Combinational; 1 after reset.
//  Latency: accept at edge N -> out_valid high after edge N. Full throughput, one word per cycle.
//  Load of output register: out_addr<=pc_q, pc_q<=pc_q+ADDR_STEP.
//  Counter: addr_load has priority over the increment. If both happen in one cycle, the word being loaded gets the old pc_q.
//   The next word gets addr_base.
//  Checks; on failure: out_instr=NOP, out_err=1, address still consumed:
//   I, S: -2048..2047. SB: -4096..4094, imm[0]=0. UJ: -2^20..2^20-2, imm[0]=0.
//   U: imm[11:0]=0. SH: imm[31:5]=0. R, LI: always legal.
//  Packing is bit-exact per ISA section 2.3. SH = {funct7, imm[4:0], rs1, funct3, rd, opcode}. R ignores in_imm.
//  LI: lo=sext(imm[11:0]), hi=(imm+0x800)>>12 (mod 2^20).
//   lo==imm -> single ADDI rd,x0,lo; stay in S_IDLE.
//   Otherwise emit LUI rd,hi, latch ADDI rd,rd,lo, go to S_LI2.
//  S_LI2: in_ready=0. When out_ready consumes the LUI, load ADDI into the output register (address +4), return to S_IDLE.
//  LI with rd=x0: encoded normally, no error.
//  States: S_IDLE, S_LI2 only. rst in S_LI2 drops the pending ADDI.
// STRUCTURE
//  Shared package riscv_pkg:
//   - typedef enum logic[2:0] imm_fmt_e (I,S,SB,U,UJ,SH,LI,R), same codes as the decode selector.
//   - OPC_LUI=7'b0110111, OPC_ITYPE=7'b0010011, INSTR_NOP=32'h00000013.
//  Sub-module instr_pack: combinational packer + range checker (fmt, fields, imm -> instr, err).
//   Instantiated once; LI halves are built from it with fmt U and fmt I.
//  Top level holds FSM, output register, pending-ADDI register and pc_q.
// TESTING
//  1 I: addi x1,x2,-1 (op 0010011, imm 0xFFFFFFFF) -> out_instr 0xFFF10093, out_addr 0, out_err 0.
//  2 SB: beq x1,x2,+8 (op 1100011) -> 0x00208463.
//    Same with imm 7 -> 0x00000013, out_err 1, out_addr 4.
//  3 LI x5,0x12345FFF -> 0x123462B7 @0 then 0xFFF28293 @4; in_ready=0 for that cycle.
//    LI x5,100 -> single 0x06400293.
//  4 Backpressure: out_ready=0 for 3 cycles -> out_* stable, in_ready=0.
//    addr_load=1, addr_base=0x100 on the handshake edge -> current word keeps old addr, next word @0x100.
//  5 Range: SH imm 32 -> err. U imm 0x12345001 -> err. UJ imm 0x000FFFFE -> legal 0x7FFFF0EF (rd x1, op 1101111).
//  6 Async rst asserted mid-cycle in S_LI2 -> out_valid=0 without a clock edge.
//    After release: no ADDI emitted, in_ready=1, next word @0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module     : riscv_pkg
// Description: Shared RV32I encode/decode definitions. The immediate-format
//              selector codes match the decode side.
//              Contents: imm_fmt_e, OPC_LUI, OPC_ITYPE, INSTR_NOP, sext12().
// Revision   : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_I  = 3'b000,
    FMT_S  = 3'b001,
    FMT_SB = 3'b010,
    FMT_U  = 3'b011,
    FMT_UJ = 3'b100,
    FMT_SH = 3'b101,
    FMT_LI = 3'b110,
    FMT_R  = 3'b111
  } imm_fmt_e;

  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [6:0]  OPC_ITYPE = 7'b0010011;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Sign-extend a 12-bit immediate to 32 bits.
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module     : instr_pack
// Description: Combinational RV32I packer and immediate range checker.
//              Ports: i_fmt, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7,
//                     i_imm (in); o_instr, o_err (out).
//              o_instr is the raw packed word; the caller substitutes the NOP
//              when o_err is set. FMT_LI is never presented here (the top
//              splits it into U and I halves) and falls back to R packing.
// Revision   : 1.0 - initial release
// ============================================================================
module instr_pack
  import riscv_pkg::*;
(
  input  imm_fmt_e    i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr,
  output logic        o_err
);

  // Signed range checks reduce to "all upper bits equal the sign bit".
  logic w_fits12;
  logic w_fits13;
  logic w_fits21;

  assign w_fits12 = (i_imm[31:11] == {21{i_imm[31]}});
  assign w_fits13 = (i_imm[31:12] == {20{i_imm[31]}});
  assign w_fits21 = (i_imm[31:20] == {12{i_imm[31]}});

  always_comb begin
    o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
    o_err   = 1'b0;
    case (i_fmt)
      FMT_I: begin
        o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        o_err   = !w_fits12;
      end
      FMT_S: begin
        o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        o_err   = !w_fits12;
      end
      FMT_SB: begin
        o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                   i_imm[4:1], i_imm[11], i_opcode};
        o_err   = !w_fits13 || i_imm[0];
      end
      FMT_U: begin
        o_instr = {i_imm[31:12], i_rd, i_opcode};
        o_err   = (i_imm[11:0] != 12'h000);
      end
      FMT_UJ: begin
        o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        o_err   = !w_fits21 || i_imm[0];
      end
      FMT_SH: begin
        o_instr = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
        o_err   = (i_imm[31:5] != 27'd0);
      end
      default: begin
        o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        o_err   = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module     : instr_encoder
// Description: RV32I instruction encoder with LI pseudo-op expansion and a
//              running byte-address tag on every emitted word.
//              Inputs : clk, rst, in_valid, in_fmt, in_opcode, in_rd, in_rs1,
//                       in_rs2, in_funct3, in_funct7, in_imm, addr_load,
//                       addr_base, out_ready
//              Outputs: in_ready, out_valid, out_instr, out_addr, out_err
// Revision   : 1.0 - initial release
// ============================================================================
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             addr_load,
  input  logic [WIDTH-1:0] addr_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_addr,
  output logic             out_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LI2  = 1'b1
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [4:0]       r_li_rd;   // pending ADDI: destination register
  logic [11:0]      r_li_lo;   // pending ADDI: low 12 immediate bits

  // LI split: lo is the sign-extended low part, hi rounds up so that
  // (hi << 12) + lo reproduces the full value.
  logic [WIDTH-1:0] w_li_lo;
  logic [WIDTH-1:0] w_li_hi_imm;
  logic             w_li_single;
  logic             w_is_li;

  assign w_li_lo     = sext12(in_imm[11:0]);
  assign w_li_hi_imm = (in_imm + 32'h0000_0800) & 32'hFFFF_F000;
  assign w_li_single = (w_li_lo == in_imm);
  assign w_is_li     = (in_fmt == FMT_LI);

  // Packer operand mux: the pending ADDI in S_LI2, the LUI/ADDI half of an
  // LI request, or the request fields unchanged.
  imm_fmt_e    w_fmt;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm;
  logic [31:0] w_instr;
  logic        w_err;

  always_comb begin
    w_fmt    = imm_fmt_e'(in_fmt);
    w_opcode = in_opcode;
    w_rd     = in_rd;
    w_rs1    = in_rs1;
    w_rs2    = in_rs2;
    w_funct3 = in_funct3;
    w_funct7 = in_funct7;
    w_imm    = in_imm;
    if (r_state == S_LI2) begin
      w_fmt    = FMT_I;
      w_opcode = OPC_ITYPE;
      w_rd     = r_li_rd;
      w_rs1    = r_li_rd;
      w_funct3 = 3'b000;
      w_imm    = sext12(r_li_lo);
    end else if (w_is_li) begin
      w_funct3 = 3'b000;
      w_rs1    = 5'd0;
      if (w_li_single) begin
        w_fmt    = FMT_I;
        w_opcode = OPC_ITYPE;
        w_imm    = in_imm;
      end else begin
        w_fmt    = FMT_U;
        w_opcode = OPC_LUI;
        w_imm    = w_li_hi_imm;
      end
    end
  end

  instr_pack u_pack (
    .i_fmt    (w_fmt),
    .i_opcode (w_opcode),
    .i_rd     (w_rd),
    .i_rs1    (w_rs1),
    .i_rs2    (w_rs2),
    .i_funct3 (w_funct3),
    .i_funct7 (w_funct7),
    .i_imm    (w_imm),
    .o_instr  (w_instr),
    .o_err    (w_err)
  );

  logic w_accept;
  logic w_load;

  assign in_ready = (r_state == S_IDLE) && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  // In S_LI2 the LUI is in the output register; its consumption frees the
  // slot for the pending ADDI.
  assign w_load   = w_accept || ((r_state == S_LI2) && out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_li_rd   <= '0;
      r_li_lo   <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
    end else begin
      if (w_load) begin
        out_valid <= 1'b1;
        out_instr <= w_err ? INSTR_NOP : w_instr;
        out_err   <= w_err;
        out_addr  <= r_pc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A load that coincides with an emitted word still tags that word
      // with the old counter value.
      if (addr_load) begin
        r_pc <= addr_base;
      end else if (w_load) begin
        r_pc <= r_pc + WIDTH'(ADDR_STEP);
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_li && !w_li_single) begin
            r_state <= S_LI2;
            r_li_rd <= in_rd;
            r_li_lo <= in_imm[11:0];
          end
        end
        S_LI2: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
